// File: rtl/defines_package.sv
// -----------------------------------------------------------------------------
// defines_package
// Shared definitions for the wireframe path:
//   Color                - packed 24-bit RGB pixel colour
//   RED/GREEN/BLUE/...   - a few named colours
//   WIREFRAME_ADDR_SIZE  - address width of the 1-bit wireframe buffer
//   SCREEN_WIDTH/HEIGHT  - default screen dimensions
//   scan_state_t         - scanout FSM state encoding
// -----------------------------------------------------------------------------
package defines_package;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  localparam Color BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam Color WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam Color RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam Color GREEN = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam Color BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hFF};

  localparam int SCREEN_WIDTH        = 64;
  localparam int SCREEN_HEIGHT       = 64;
  localparam int WIREFRAME_ADDR_SIZE = 12;  // 64*64 one-bit locations

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scanout_fifo.sv
// -----------------------------------------------------------------------------
// scanout_fifo
// Two-entry synchronous FIFO between the buffer read capture and the pixel
// output port. Head data is visible on dout whenever the FIFO is non-empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write one entry (ignored when full)
//   pop           remove the head entry (ignored when empty)
//   dout          head entry
//   count         number of stored entries (0..2)
//   empty, full   occupancy flags
// -----------------------------------------------------------------------------
module scanout_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wireframe_scanout.sv
// -----------------------------------------------------------------------------
// wireframe_scanout
// Sweeps the 1-bit wireframe buffer in raster order, maps each bit to the
// foreground/background colour and streams pixels out on a valid/ready port.
// Optionally clears every location right after it has been read.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start                      pulse: begin a frame (only honoured when idle)
//   clear_on_read              sampled with start: clear-behind-read enable
//   fg_color, bg_color         colours for bit=1 / bit=0, sampled with start
//   rd_en, rd_addr, rd_data    buffer read port (rd_data one cycle after rd_en)
//   clr_en, clr_addr           buffer clear port (write data is always 0)
//   px_valid, px_ready         pixel stream handshake
//   px_color, px_x, px_y       pixel payload
//   px_sof, px_eol             first pixel of frame / last pixel of line
//   busy                       frame in progress
//   done                       pulse: every pixel of the frame delivered
// -----------------------------------------------------------------------------
module wireframe_scanout
  import defines_package::*;
#(
  parameter int H_RES  = SCREEN_WIDTH,
  parameter int V_RES  = SCREEN_HEIGHT,
  parameter int ADDR_W = WIREFRAME_ADDR_SIZE,
  parameter int X_W    = $clog2(H_RES),
  parameter int Y_W    = $clog2(V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_on_read,
  input  Color              fg_color,
  input  Color              bg_color,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              px_valid,
  input  logic              px_ready,
  output Color              px_color,
  output logic [X_W-1:0]    px_x,
  output logic [Y_W-1:0]    px_y,
  output logic              px_sof,
  output logic              px_eol,
  output logic              busy,
  output logic              done
);

  localparam int PAYLOAD_W = $bits(Color) + X_W + Y_W + 2;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  scan_state_t    state_reg, state_next;
  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;
  Color           fg_reg;
  Color           bg_reg;
  logic           clear_reg;

  // Read issued last cycle; its data arrives on rd_data this cycle.
  logic           inflight_reg;
  logic [X_W-1:0] cap_x_reg;
  logic [Y_W-1:0] cap_y_reg;

  logic           issue;
  logic           start_accept;
  logic           frame_done;
  logic           x_last;
  logic           y_last;

  // FIFO plumbing
  logic                 push;
  logic                 pop;
  logic [PAYLOAD_W-1:0] push_data;
  logic [PAYLOAD_W-1:0] head_data;
  logic [1:0]           fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [2:0]           credits_used;

  Color           cap_color;
  logic           cap_sof;
  logic           cap_eol;
  Color           head_color;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic           head_sof;
  logic           head_eol;

  assign x_last = (x_reg == X_W'(H_RES - 1));
  assign y_last = (y_reg == Y_W'(V_RES - 1));

  assign pop  = ~fifo_empty & px_ready;
  assign push = inflight_reg;

  // Slots committed downstream: stored entries plus the read in flight. The
  // entry leaving this cycle frees its slot immediately, which is what lets
  // the scan sustain one read per clock while the consumer keeps up. The next
  // cycle's occupancy is then at most 2, so the FIFO can never overflow.
  assign credits_used = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    issue        = 1'b0;
    start_accept = 1'b0;
    frame_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (credits_used < 3'd2) begin
          issue = 1'b1;
          if (x_last && y_last) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // With no reads left to issue, an empty FIFO and nothing in flight
        // mean the final pixel has already been handed over.
        if (fifo_empty && !inflight_reg) begin
          frame_done = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_reg != ST_IDLE) && !frame_done;
  assign done  = frame_done;
  assign rd_en = issue;

  // ---------------------------------------------------------------------------
  // Frame settings and raster counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_reg    <= '0;
      bg_reg    <= '0;
      clear_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else if (start_accept) begin
      fg_reg    <= fg_color;
      bg_reg    <= bg_color;
      clear_reg <= clear_on_read;
      x_reg     <= '0;
      y_reg     <= '0;
    end else if (issue) begin
      if (x_last) begin
        x_reg <= '0;
        y_reg <= y_last ? '0 : y_reg + Y_W'(1);
      end else begin
        x_reg <= x_reg + X_W'(1);
      end
    end
  end

  assign rd_addr = lin_addr(x_reg, y_reg);

  // ---------------------------------------------------------------------------
  // Capture: remember where the outstanding read points so its data can be
  // tagged when it returns.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= 1'b0;
      cap_x_reg    <= '0;
      cap_y_reg    <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        cap_x_reg <= x_reg;
        cap_y_reg <= y_reg;
      end
    end
  end

  assign cap_color = rd_data ? fg_reg : bg_reg;
  assign cap_sof   = (cap_x_reg == '0) && (cap_y_reg == '0);
  assign cap_eol   = (cap_x_reg == X_W'(H_RES - 1));
  assign push_data = {cap_color, cap_x_reg, cap_y_reg, cap_sof, cap_eol};

  // The location is cleared on the buffer's second port in the same cycle its
  // data is captured, so the read has already completed.
  assign clr_en   = inflight_reg & clear_reg;
  assign clr_addr = clr_en ? lin_addr(cap_x_reg, cap_y_reg) : '0;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  scanout_fifo #(
    .W (PAYLOAD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (head_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign {head_color, head_x, head_y, head_sof, head_eol} = head_data;

  // Payload is forced to zero while nothing is on offer so stale entries never
  // show on the port.
  assign px_valid = ~fifo_empty;
  assign px_color = px_valid ? head_color : '0;
  assign px_x     = px_valid ? head_x : '0;
  assign px_y     = px_valid ? head_y : '0;
  assign px_sof   = px_valid & head_sof;
  assign px_eol   = px_valid & head_eol;

endmodule

// File: tb/tb_wireframe_scanout.sv
module tb_wireframe_scanout;
  import defines_package::*;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int AW   = 3;
  localparam int XW   = 2;
  localparam int YW   = 1;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          clear_on_read = 1'b0;
  Color          fg_color = BLACK;
  Color          bg_color = BLACK;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_data;
  logic          clr_en;
  logic [AW-1:0] clr_addr;
  logic          px_valid;
  logic          px_ready = 1'b0;
  Color          px_color;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic          px_sof;
  logic          px_eol;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  wireframe_scanout #(
    .H_RES (H), .V_RES (V), .ADDR_W (AW), .X_W (XW), .Y_W (YW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .clear_on_read (clear_on_read),
    .fg_color (fg_color), .bg_color (bg_color),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
    .clr_en (clr_en), .clr_addr (clr_addr),
    .px_valid (px_valid), .px_ready (px_ready), .px_color (px_color),
    .px_x (px_x), .px_y (px_y), .px_sof (px_sof), .px_eol (px_eol),
    .busy (busy), .done (done)
  );

  // Dual-port 1-bit buffer: registered read port, clear port, bench load.
  logic [NPIX-1:0] mem;
  logic            load_req = 1'b0;
  logic [NPIX-1:0] load_val = '0;

  always @(posedge clk) begin
    if (load_req) mem <= load_val;
    else if (clr_en) mem[clr_addr] <= 1'b0;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  typedef struct packed {
    Color          c;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
  } pix_t;

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_xfer_cyc = -10;
  int   outstanding = 0;
  bit   prev_stall = 0;
  pix_t prev_pix;
  logic s_rd_en, s_valid, s_busy;
  pix_t got_q[$];
  int   xfer_cyc_q[$];
  int   rd_q[$];
  int   rd_cyc_q[$];
  int   clr_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, record and check, then return
  // just after the next rising edge where the caller drives new inputs.
  task automatic sample();
    pix_t cur;
    bit   xfer;
    @(negedge clk);
    cur  = '{c: px_color, x: px_x, y: px_y, sof: px_sof, eol: px_eol};
    xfer = px_valid && px_ready;
    s_rd_en = rd_en; s_valid = px_valid; s_busy = busy;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", px_valid, 1'b1);
        chk("hold_payload", cur, prev_pix);
      end
      if (rd_en) chk("read_credit", (outstanding - int'(xfer)) < 2, 1'b1);
      chk("fifo_no_overflow", dut.push && dut.fifo_full && !dut.pop, 1'b0);
      if (rd_en) begin rd_q.push_back(int'(rd_addr)); rd_cyc_q.push_back(cyc); end
      if (xfer) begin got_q.push_back(cur); xfer_cyc_q.push_back(cyc); last_xfer_cyc = cyc; end
      if (clr_en) clr_q.push_back(int'(clr_addr));
      if (done) begin
        done_cnt++;
        chk("done_after_last_xfer", cyc, last_xfer_cyc + 1);
        chk("busy_low_on_done", busy, 1'b0);
      end
      outstanding = outstanding + int'(rd_en) - int'(xfer);
      prev_stall  = px_valid && !px_ready;
      prev_pix    = cur;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input logic [NPIX-1:0] bits);
    load_val = bits;
    load_req = 1'b1;
    sample();
    load_req = 1'b0;
  endtask

  function automatic logic ready_of(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 2) == 1;
      2: return (k <= 6) ? ((k % 2) == 1) : (k >= 12);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk(tag, {rd_en, rd_addr, clr_en, clr_addr, px_valid, px_color, px_x, px_y,
              px_sof, px_eol, busy, done}, '0);
  endtask

  task automatic run_frame(input string name, input logic [NPIX-1:0] bits,
                           input logic cor, input Color fg, input Color bg,
                           input int mode, input bit spurious);
    int   g0, r0, c0, d0, s;
    bit   got_done;
    pix_t e;
    g0 = got_q.size(); r0 = rd_q.size(); c0 = clr_q.size(); d0 = done_cnt;
    got_done = 0;
    start = 1'b1; clear_on_read = cor; fg_color = fg; bg_color = bg;
    px_ready = ready_of(mode, 0);
    s = cyc;
    sample();
    start = 1'b0;
    // Scramble the sampled inputs: the frame must use the latched values.
    fg_color = ~fg; bg_color = ~bg; clear_on_read = ~cor;
    for (int k = 1; k < 300; k++) begin
      px_ready = ready_of(mode, k);
      if (spurious && (k == 4 || done)) start = 1'b1;
      sample();
      start = 1'b0;
      if (mode == 2 && k == 11) begin
        chk({name, "_stall_no_read"}, s_rd_en, 1'b0);
        chk({name, "_stall_valid"}, s_valid, 1'b1);
      end
      if (done_cnt != d0) begin got_done = 1; break; end
    end
    chk({name, "_done_seen"}, got_done, 1'b1);
    px_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      sample();
      chk({name, "_idle_after_done"}, s_busy, 1'b0);
    end
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_pixel_count"}, got_q.size() - g0, NPIX);
    chk({name, "_read_count"}, rd_q.size() - r0, NPIX);
    chk({name, "_clear_count"}, clr_q.size() - c0, cor ? NPIX : 0);
    for (int i = 0; i < NPIX; i++) begin
      e.c   = bits[i] ? fg : bg;
      e.x   = XW'(i % H);
      e.y   = YW'(i / H);
      e.sof = (i == 0);
      e.eol = ((i % H) == H - 1);
      if (g0 + i < got_q.size()) chk({name, "_pixel"}, got_q[g0 + i], e);
      if (r0 + i < rd_q.size()) chk({name, "_read_addr"}, rd_q[r0 + i], i);
      if (cor && c0 + i < clr_q.size()) chk({name, "_clear_addr"}, clr_q[c0 + i], i);
    end
    if (mode == 0 && rd_q.size() - r0 == NPIX && got_q.size() - g0 == NPIX) begin
      chk({name, "_first_read_latency"}, rd_cyc_q[r0] - s, 1);
      chk({name, "_last_read_cycle"}, rd_cyc_q[r0 + NPIX - 1] - s, NPIX);
      chk({name, "_first_pixel_latency"}, xfer_cyc_q[g0] - s, 3);
    end
    if (cor) chk({name, "_buffer_cleared"}, mem, '0);
    $display("frame %s: %0d pixels, %0d reads, %0d clears", name,
             got_q.size() - g0, rd_q.size() - r0, clr_q.size() - c0);
  endtask

  initial begin
    logic [NPIX-1:0] bits;
    logic            cor;
    int              g0, c0, d0;
    Color            fg, bg;

    // Reset state
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset_outputs_zero");
    @(posedge clk); #1;
    sample();
    check_outputs_zero("reset_held_outputs_zero");
    rst = 1'b0;
    sample();

    // 1: blank buffer, full-rate consumer
    load('0);
    run_frame("t1_blank", '0, 1'b0, RED, BLACK, 0, 0);

    // 2: two set bits with clear-behind-read, then a blank follow-up frame
    bits = 8'b0100_0010;
    load(bits);
    run_frame("t2_clear", bits, 1'b1, RED, BLACK, 0, 0);
    run_frame("t2_after", '0, 1'b0, RED, BLACK, 0, 0);

    // 3: toggling ready then a five-cycle stall mid-line
    bits = NPIX'($urandom);
    load(bits);
    run_frame("t3_backpressure", bits, 1'b0, RED, BLACK, 2, 0);

    // 4: start re-pulsed during the scan and on the done cycle
    bits = 8'b1000_0001;
    load(bits);
    run_frame("t4_spurious_start", bits, 1'b0, RED, BLACK, 0, 1);

    // 5: reset after three pixels
    bits = 8'b0011_1100;
    load(bits);
    g0 = got_q.size();
    start = 1'b1; clear_on_read = 1'b1; fg_color = RED; bg_color = BLACK; px_ready = 1'b1;
    sample();
    start = 1'b0;
    for (int k = 0; k < 50 && got_q.size() - g0 < 3; k++) sample();
    chk("t5_three_pixels_before_reset", got_q.size() - g0, 3);
    rst = 1'b1;
    #1 check_outputs_zero("t5_reset_outputs_zero");
    outstanding = 0;
    prev_stall  = 0;
    c0 = clr_q.size();
    d0 = done_cnt;
    sample();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) sample();
    chk("t5_no_done_after_reset", done_cnt - d0, 0);
    chk("t5_no_clear_after_reset", clr_q.size() - c0, 0);
    chk("t5_idle_after_reset", s_busy, 1'b0);
    load(bits);
    run_frame("t5_restart", bits, 1'b1, RED, BLACK, 0, 0);

    // 6: no clearing; the repeat frame shows identical pixels
    bits = 8'b1010_0101;
    load(bits);
    run_frame("t6_keep_a", bits, 1'b0, RED, BLACK, 1, 0);
    run_frame("t6_keep_b", bits, 1'b0, RED, BLACK, 0, 0);
    chk("t6_buffer_intact", mem, bits);

    // Randomised frames with random colours, clear mode and consumer
    for (int r = 0; r < 4; r++) begin
      bits = NPIX'($urandom);
      cor  = 1'($urandom_range(0, 1));
      fg   = Color'($urandom);
      bg   = Color'($urandom);
      load(bits);
      run_frame("rnd", bits, cor, fg, bg, 3, 0);
      run_frame("rnd_repeat", cor ? '0 : bits, 1'b0, fg, bg, 3, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wireframe_scanout.md
Name: wireframe_scanout

Overview:
- Read-side counterpart to the rasterizer's wireframe write port (write_en/addr/wf_data).
- Sweeps the 1-bit wireframe buffer in raster order through the buffer's read port. Maps each bit to fg/bg Color.
- Streams pixels to the display/output stage on a valid/ready interface with backpressure.
- Optionally clears each location after reading it, so the next frame starts blank.

Parameters:
- H_RES, 64, pixels per line.
- V_RES, 64, lines per frame; H_RES*V_RES <= 2**ADDR_W.
- ADDR_W, WIREFRAME_ADDR_SIZE, buffer address width.
- X_W, $clog2(H_RES), px_x width.
- Y_W, $clog2(V_RES), px_y width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse: begin a frame scan; ignored unless idle.
- clear_on_read  in  1  sampled with start: enables clear-behind-read for this frame.
- fg_color  in  Color  colour for bit=1; sampled with start.
- bg_color  in  Color  colour for bit=0; sampled with start.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  read address = y*H_RES + x.
- rd_data  in  1  buffer bit; valid exactly 1 cycle after rd_en.
- clr_en  out  1  write strobe to the buffer's second port (data is always 0).
- clr_addr  out  ADDR_W  address being cleared.
- px_valid  out  1  pixel available.
- px_ready  in  1  consumer accepts pixel.
- px_color  out  Color  pixel colour.
- px_x  out  X_W  pixel column.
- px_y  out  Y_W  pixel row.
- px_sof  out  1  first pixel of frame (0,0).
- px_eol  out  1  last pixel of line.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse: frame fully delivered.

Behaviour:
- Reset: every output 0, FSM IDLE, counters 0, FIFO empty, in-flight read flag cleared.
  - Reset mid-frame aborts immediately; no trailing clr_en or done.
- FSM states:
  - IDLE: start=1 -> SCAN. Latch colours and clear_on_read; read counters x,y := 0; busy=1 from the next cycle.
  - SCAN: issue reads (rules below). After the read of (H_RES-1, V_RES-1) is issued -> DRAIN.
  - DRAIN: no new reads. When FIFO empty, no read in flight, and the last pixel handshake has occurred -> IDLE. done=1 for exactly that cycle; busy=0 in the same cycle.
- Read issue:
  - rd_en=1 iff state==SCAN and (FIFO count + in-flight) < 2. FIFO is 2 entries.
  - On issue, advance x; on x wrap (H_RES-1 -> 0) advance y.
  - Sustained throughput is 1 pixel/clk while px_ready=1.
- Data capture:
  - The cycle after rd_en, push {rd_data ? fg : bg, x, y, sof, eol} into the FIFO.
  - The credit rule guarantees no overflow. Overflow is a design error; bench asserts it never occurs.
- Clear-behind-read: if the latched clear_on_read=1, clr_en=1 with clr_addr = captured address in the capture cycle.
  - The buffer must be dual-port. The rasterizer must not write while busy=1 (system rule, not checked here).
- Output:
  - px_* driven from FIFO head; px_valid = FIFO non-empty.
  - A transfer occurs when px_valid & px_ready; pop on transfer.
  - Payload is held stable while px_valid=1 and px_ready=0.
- Latency: start -> first rd_en 1 cycle. First rd_en -> px_valid 2 cycles (registered capture into FIFO).
- Simultaneous push and pop: count unchanged.
- start in SCAN/DRAIN: ignored. start on the cycle done=1: ignored; re-issue from IDLE.
- Non-power-of-two H_RES: address computed as y*H_RES + x (constant-multiply) or an incremented register. No gaps.

Decomposition:
- defines_package holds Color, WIREFRAME_ADDR_SIZE, default screen dimensions, and the FSM state enum (scan_state_t).
- One sub-module: scanout_fifo — 2-entry synchronous FIFO.
  - Parameterised payload width; push/pop/count/empty/full.
  - Reset asynchronous, active-high.

Test Plan (H_RES=4, V_RES=2, fg=RED, bg=BLACK unless stated):
1. Buffer all 0, px_ready=1, start -> 8 pixels BLACK in order (0,0)..(3,1); rd_en at cycles 1-8; px_sof only on (0,0); px_eol on x=3; done pulse one cycle after the last transfer; busy low the same cycle.
2. Bits at addresses 1 and 6 set, clear_on_read=1 -> (1,0) and (2,1) RED, others BLACK; clr_en asserted for addresses 0..7 once each; second frame all BLACK.
3. px_ready toggling 1010..., then held 0 for 5 cycles mid-line -> no pixel lost or duplicated; rd_en stalls with FIFO full; px_color stable while stalled.
4. start pulsed again during SCAN and on the done cycle -> ignored; exactly one done per accepted start.
5. rst asserted mid-frame (after 3 pixels) -> all outputs 0 on the next edge; no done; a new start yields a complete 8-pixel frame from (0,0).
6. clear_on_read=0 -> clr_en never asserted; repeating the frame returns identical pixels.
